// File: rtl/vga_tile_scheduler.sv
// vga_tile_scheduler
//
// Purpose:
//   Tile-map display controller that sits between the game logic and the VGA
//   timing driver. It owns one external single-port cell-map RAM holding a
//   40x30 grid of 4-bit colour indices, where each cell covers 16x16 pixels.
//   During blanking it prefetches one cell row into a 40-entry line buffer.
//   During active video it serves RGB444 pixels through a programmable
//   16-entry palette. The display fetch always has priority on the RAM.
//   Game-logic writes are granted only when the fetch engine is idle.
//
// Ports:
//   vga_clk     pixel clock
//   sys_rst     synchronous reset, active-high
//   vga_vs      frame sync from the timing driver, active-low
//   pixel_xpos  requested pixel column 1..H_DISP, 0 = no request
//   pixel_ypos  requested pixel line 1..480, 0 = no request
//   pixel_data  RGB444 for the pixel requested one cycle earlier
//   mem_addr    cell-map RAM address
//   mem_we      cell-map RAM write strobe
//   mem_wdata   cell-map RAM write data
//   mem_rdata   cell-map RAM read data, valid one cycle after the address
//   wr_req      game-logic write request (held until wr_ack)
//   wr_addr     game-logic write address, row*COLS+col
//   wr_data     game-logic write colour index
//   wr_ack      write issued to the RAM this cycle
//   pal_we      palette write strobe
//   pal_idx     palette entry index
//   pal_data    palette entry RGB444
//   fetch_busy  high while the fetch engine owns the RAM
//   sched_err   sticky flag: pixel requested while a fetch was running

module vga_tile_scheduler #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int CELL_SHIFT = 4,
    parameter int H_DISP     = 640
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        vga_vs,
    input  logic [9:0]  pixel_xpos,
    input  logic [9:0]  pixel_ypos,
    output logic [11:0] pixel_data,
    output logic [10:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wdata,
    input  logic [3:0]  mem_rdata,
    input  logic        wr_req,
    input  logic [10:0] wr_addr,
    input  logic [3:0]  wr_data,
    output logic        wr_ack,
    input  logic        pal_we,
    input  logic [3:0]  pal_idx,
    input  logic [11:0] pal_data,
    output logic        fetch_busy,
    output logic        sched_err
);

    localparam int         V_DISP   = ROWS << CELL_SHIFT;
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t      state;
    logic [5:0]  col;
    logic [10:0] row_base;
    logic        vs_d;

    logic [3:0]  linebuf [0:COLS-1];
    logic [11:0] pal     [0:15];

    logic        frame_trig;
    logic        row_trig;
    logic        trig;
    logic        write_grant;

    logic [9:0]  x_off;
    logic [9:0]  cell_idx;
    logic [3:0]  cell_colour;

    // A frame starts on the rising edge of the active-low vsync. A row fetch
    // is requested at the last active pixel of the final line of a cell row,
    // which gives the whole horizontal blanking interval to refill the buffer.
    assign frame_trig = ~vs_d & vga_vs;
    assign row_trig   = (pixel_xpos == 10'(H_DISP))
                      && (pixel_ypos[CELL_SHIFT-1:0] == '0)
                      && (pixel_ypos < 10'(V_DISP));
    assign trig       = frame_trig | row_trig;

    // A trigger seen in IDLE wins over a pending write; that write is then
    // granted on the first IDLE cycle after the fetch completes.
    assign write_grant = (state == IDLE) && !trig && wr_req;

    assign fetch_busy = (state != IDLE);

    // RAM port mux: the fetch address while fetching, otherwise a same-cycle
    // pass-through of a granted game-logic write.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        if (!sys_rst) begin
            if (state == FETCH) begin
                mem_addr = row_base + {5'd0, col};
            end else if (write_grant) begin
                mem_addr  = wr_addr;
                mem_we    = 1'b1;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
            end
        end
    end

    // Fetch engine: 40 issue cycles followed by one drain cycle for the last
    // read word. row_base tracks the first address of the current cell row.
    // It steps by COLS per row trigger, so no multiplier is needed.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            col       <= '0;
            row_base  <= '0;
            vs_d      <= 1'b1;
            sched_err <= 1'b0;
        end else begin
            vs_d <= vga_vs;
            if ((pixel_xpos != '0) && (state != IDLE)) begin
                sched_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (trig) begin
                        state <= FETCH;
                        col   <= '0;
                        if (frame_trig) begin
                            row_base <= '0;
                        end else begin
                            row_base <= row_base + 11'(COLS);
                        end
                    end
                end
                FETCH: begin
                    col <= col + 6'd1;
                    if (col == LAST_COL) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data returns one cycle after issue, when col has already advanced.
    // The word therefore belongs to entry col-1, including in DRAIN.
    // Contents are deliberately not reset.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst && (((state == FETCH) && (col != '0)) || (state == DRAIN))) begin
            linebuf[col - 6'd1] <= mem_rdata;
        end
    end

    // Columns are 1-based, so column x lives in cell (x-1)>>CELL_SHIFT.
    // Requests beyond the last cell read as colour 0 instead of indexing
    // outside the buffer.
    assign x_off       = pixel_xpos - 10'd1;
    assign cell_idx    = x_off >> CELL_SHIFT;
    assign cell_colour = (cell_idx < 10'(COLS)) ? linebuf[cell_idx[5:0]] : 4'd0;

    // Pixel lookup and palette update share one register stage. A palette
    // write in the same cycle as a read of that entry returns the old value.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            pixel_data <= '0;
            for (int i = 0; i < 16; i++) begin
                pal[i] <= {i[3:0], i[3:0], i[3:0]};
            end
        end else begin
            if (pal_we) begin
                pal[pal_idx] <= pal_data;
            end
            if (pixel_xpos != '0) begin
                pixel_data <= pal[cell_colour];
            end else begin
                pixel_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_tile_scheduler.sv
// tb_vga_tile_scheduler
//
// Purpose:
//   Self-checking bench for vga_tile_scheduler. It models the external
//   cell-map RAM and keeps a behavioural reference of the cell map, the line
//   buffer and the palette. Expected pixels and addresses are derived from
//   those arrays with plain arithmetic.

module tb_vga_tile_scheduler;

    logic        vga_clk;
    logic        sys_rst;
    logic        vga_vs;
    logic [9:0]  pixel_xpos;
    logic [9:0]  pixel_ypos;
    logic [11:0] pixel_data;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wdata;
    logic [3:0]  mem_rdata;
    logic        wr_req;
    logic [10:0] wr_addr;
    logic [3:0]  wr_data;
    logic        wr_ack;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [11:0] pal_data;
    logic        fetch_busy;
    logic        sched_err;

    int tests_run;
    int tests_failed;

    // Physical RAM (written only by the DUT's port or the initial load),
    // plus the reference state derived from the rules of the design.
    logic        ram_load;
    logic [3:0]  ram      [0:2047];
    logic [3:0]  init_val [0:1199];
    logic [3:0]  exp_ram  [0:1199];
    logic [3:0]  exp_lb   [0:39];
    logic [11:0] exp_pal  [0:15];

    logic [11:0] prev_exp;
    bit          prev_valid;

    vga_tile_scheduler dut (
        .vga_clk    (vga_clk),
        .sys_rst    (sys_rst),
        .vga_vs     (vga_vs),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .pixel_data (pixel_data),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .pal_we     (pal_we),
        .pal_idx    (pal_idx),
        .pal_data   (pal_data),
        .fetch_busy (fetch_busy),
        .sched_err  (sched_err)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Single-port synchronous RAM with one cycle read latency.
    always @(posedge vga_clk) begin
        if (ram_load) begin
            for (int a = 0; a < 1200; a++) ram[a] <= init_val[a];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [11:0] exp_pix(input int x);
        if (x == 0) return 12'h000;
        return exp_pal[exp_lb[(x - 1) / 16]];
    endfunction

    // One pixel-request cycle: drive after the edge, predict the result,
    // then check the previous request's pixel at the falling edge.
    task automatic applyStimulus(input int x, input int y, input bit pwe,
                                 input logic [3:0] pidx, input logic [11:0] pdat);
        logic [11:0] exp_now;
        @(posedge vga_clk); #1;
        pixel_xpos = 10'(x);
        pixel_ypos = 10'(y);
        pal_we     = pwe;
        pal_idx    = pidx;
        pal_data   = pdat;
        exp_now = exp_pix(x);
        if (pwe) exp_pal[pidx] = pdat;
        @(negedge vga_clk);
        if (prev_valid) checkOutput("pixel", {20'd0, pixel_data}, {20'd0, prev_exp});
        prev_exp   = exp_now;
        prev_valid = 1'b1;
    endtask

    task automatic pixel_run(input int n, input bit sweep, input int y, input bit pal_rand);
        int x;
        bit pwe;
        prev_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (sweep) x = i + 1;
            else if ($urandom_range(0, 9) == 0) x = 0;
            else x = $urandom_range(1, 640);
            pwe = pal_rand && ($urandom_range(0, 3) == 0);
            applyStimulus(x, y, pwe, 4'($urandom_range(0, 15)), 12'($urandom));
        end
        applyStimulus(0, y, 1'b0, 4'd0, 12'd0);
        checkOutput("err_idle", {31'd0, sched_err}, 32'd0);
    endtask

    task automatic frame_trigger();
        @(posedge vga_clk); #1;
        vga_vs = 1'b0;
        @(posedge vga_clk); #1;
        vga_vs = 1'b1;
        @(negedge vga_clk);
    endtask

    task automatic row_trigger(input int y, input bit req, input int addr, input int data);
        @(posedge vga_clk); #1;
        pixel_xpos = 10'd640;
        pixel_ypos = 10'(y);
        wr_req     = req;
        wr_addr    = 11'(addr);
        wr_data    = 4'(data);
        @(negedge vga_clk);
        checkOutput("trig_we", {31'd0, mem_we}, 32'd0);
        checkOutput("trig_busy", {31'd0, fetch_busy}, 32'd0);
    endtask

    // Follows one fetch: length, address order, no writes and no acks while
    // busy. Returns at the falling edge of the first idle cycle afterwards.
    task automatic wait_fetch(input int row);
        int busy_len, seq_err, we_seen, ack_busy;
        bit started;
        busy_len = 0; seq_err = 0; we_seen = 0; ack_busy = 0; started = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(posedge vga_clk); #1;
            pixel_xpos = 10'd0;
            pixel_ypos = 10'd0;
            @(negedge vga_clk);
            if (fetch_busy) begin
                if (busy_len < 40 && mem_addr !== 11'(row * 40 + busy_len)) seq_err++;
                if (mem_we) we_seen++;
                if (wr_ack) ack_busy++;
                busy_len++;
                started = 1'b1;
            end else if (started) begin
                break;
            end
        end
        checkOutput("busy_len", busy_len, 41);
        checkOutput("addr_seq", seq_err, 0);
        checkOutput("fetch_we", we_seen, 0);
        checkOutput("fetch_ack", ack_busy, 0);
        for (int c = 0; c < 40; c++) exp_lb[c] = exp_ram[row * 40 + c];
    endtask

    task automatic random_writes(input int n);
        bit req;
        int addr;
        logic [3:0] data;
        for (int i = 0; i < n; i++) begin
            @(posedge vga_clk); #1;
            req  = ($urandom_range(0, 1) == 1);
            addr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 1199) : $urandom_range(40, 79);
            data = 4'($urandom);
            wr_req  = req;
            wr_addr = 11'(addr);
            wr_data = data;
            @(negedge vga_clk);
            checkOutput("wr_ack", {31'd0, wr_ack}, {31'd0, req});
            if (req) begin
                checkOutput("wr_we", {31'd0, mem_we}, 32'd1);
                checkOutput("wr_addr", {21'd0, mem_addr}, addr);
                checkOutput("wr_data", {28'd0, mem_wdata}, {28'd0, data});
                exp_ram[addr] = data;
            end
        end
        @(posedge vga_clk); #1;
        wr_req = 1'b0;
    endtask

    initial begin
        int busy_seen;
        logic [3:0] v;
        tests_run = 0;
        tests_failed = 0;
        prev_valid = 1'b0;
        prev_exp = '0;
        sys_rst = 1'b1; vga_vs = 1'b1;
        pixel_xpos = '0; pixel_ypos = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        pal_we = 1'b0; pal_idx = '0; pal_data = '0;
        for (int a = 0; a < 1200; a++) begin
            v = (a < 40) ? 4'(a % 16) : 4'($urandom);
            init_val[a] = v;
            exp_ram[a]  = v;
        end
        for (int i = 0; i < 16; i++) exp_pal[i] = {4'(i), 4'(i), 4'(i)};
        for (int c = 0; c < 40; c++) exp_lb[c] = 4'd0;
        ram_load = 1'b1;

        // Reset state
        @(posedge vga_clk); #1;
        ram_load = 1'b0;
        repeat (2) begin @(posedge vga_clk); #1; end
        @(negedge vga_clk);
        checkOutput("rst_pixel", {20'd0, pixel_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, fetch_busy}, 32'd0);
        checkOutput("rst_err", {31'd0, sched_err}, 32'd0);
        checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_ack", {31'd0, wr_ack}, 32'd0);

        // No spurious fetch after release while vsync stays high
        @(posedge vga_clk); #1;
        sys_rst = 1'b0;
        busy_seen = 0;
        repeat (4) begin
            @(negedge vga_clk);
            if (fetch_busy) busy_seen++;
            @(posedge vga_clk); #1;
        end
        checkOutput("idle_after_rst", busy_seen, 0);

        // Row 0 fetch and full sweep
        frame_trigger();
        wait_fetch(0);
        pixel_run(640, 1'b1, 1, 1'b0);

        // Palette write: same-cycle read sees the old entry, later reads the new
        prev_valid = 1'b0;
        applyStimulus(49, 1, 1'b1, 4'd3, 12'hF00);
        applyStimulus(50, 1, 1'b0, 4'd0, 12'd0);
        applyStimulus(60, 1, 1'b0, 4'd0, 12'd0);
        applyStimulus(0, 1, 1'b0, 4'd0, 12'd0);
        pixel_run(150, 1'b0, 1, 1'b1);

        // Game-logic writes while idle, then row 1 fetch
        random_writes(60);
        row_trigger(16, 1'b0, 0, 0);
        wait_fetch(1);
        pixel_run(150, 1'b0, 17, 1'b1);

        // Write arriving with a trigger waits for the fetch to finish
        row_trigger(32, 1'b1, 5, 9);
        wait_fetch(2);
        checkOutput("late_ack", {31'd0, wr_ack}, 32'd1);
        checkOutput("late_we", {31'd0, mem_we}, 32'd1);
        checkOutput("late_addr", {21'd0, mem_addr}, 32'd5);
        checkOutput("late_data", {28'd0, mem_wdata}, 32'd9);
        exp_ram[5] = 4'd9;
        @(posedge vga_clk); #1;
        wr_req = 1'b0;
        @(negedge vga_clk);
        checkOutput("ack_once", {31'd0, wr_ack}, 32'd0);
        pixel_run(100, 1'b0, 33, 1'b0);

        // Line 480 is past the last cell row: no fetch
        @(posedge vga_clk); #1;
        pixel_xpos = 10'd640; pixel_ypos = 10'd480;
        busy_seen = 0;
        repeat (5) begin
            @(posedge vga_clk); #1;
            pixel_xpos = 10'd0; pixel_ypos = 10'd0;
            @(negedge vga_clk);
            if (fetch_busy) busy_seen++;
        end
        checkOutput("no_fetch_480", busy_seen, 0);

        // New frame refetches row 0 including the delayed write
        frame_trigger();
        wait_fetch(0);
        prev_valid = 1'b0;
        applyStimulus(81, 1, 1'b0, 4'd0, 12'd0);
        applyStimulus(0, 1, 1'b0, 4'd0, 12'd0);
        pixel_run(100, 1'b0, 1, 1'b0);

        // Pixel request during a fetch sets the sticky error, reset clears it
        frame_trigger();
        @(posedge vga_clk); #1;
        @(negedge vga_clk);
        checkOutput("err_busy", {31'd0, fetch_busy}, 32'd1);
        @(posedge vga_clk); #1;
        pixel_xpos = 10'd100; pixel_ypos = 10'd1;
        @(posedge vga_clk); #1;
        pixel_xpos = 10'd0; pixel_ypos = 10'd0;
        @(negedge vga_clk);
        checkOutput("err_set", {31'd0, sched_err}, 32'd1);
        repeat (2) begin @(posedge vga_clk); #1; end
        @(negedge vga_clk);
        checkOutput("err_hold", {31'd0, sched_err}, 32'd1);
        @(posedge vga_clk); #1;
        sys_rst = 1'b1;
        @(posedge vga_clk); #1;
        sys_rst = 1'b0;
        @(negedge vga_clk);
        checkOutput("err_clr", {31'd0, sched_err}, 32'd0);
        checkOutput("rst_abort", {31'd0, fetch_busy}, 32'd0);
        for (int i = 0; i < 16; i++) exp_pal[i] = {4'(i), 4'(i), 4'(i)};

        // Fresh fetch after the aborted one, read through the reset palette
        frame_trigger();
        wait_fetch(0);
        pixel_run(100, 1'b0, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
